// File: rtl/tmds_pkg.sv
// Shared types and constants for the TMDS link sequencer: state encoding,
// DVI control tokens and the clock-channel pattern.
package tmds_pkg;

  localparam int unsigned kWordW    = 10;
  localparam int unsigned kLossCntW = 8;

  typedef logic [kWordW-1:0] tmds_word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    WARMUP   = 2'd2,
    LINK_UP  = 2'd3
  } link_state_e;

  // One word per data channel, as presented to the serializers.
  typedef struct packed {
    tmds_word_t ch2;
    tmds_word_t ch1;
    tmds_word_t ch0;
  } tmds_rgb_t;

  localparam tmds_word_t kCtl00      = 10'h354;
  localparam tmds_word_t kCtl01      = 10'h0AB;
  localparam tmds_word_t kCtl10      = 10'h154;
  localparam tmds_word_t kCtl11      = 10'h2AB;
  localparam tmds_word_t kClkPattern = 10'h3E0;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of the shared phase counter; the largest terminal value is max-1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c));
  endfunction

endpackage

// File: rtl/tmds_link_ctrl_if.sv
// Link-side signal bundle for tmds_link_ctrl. pLockLossCnt exists only when
// TMDS_LINK_DIAG_EN is defined.
interface tmds_link_ctrl_if;
  import tmds_pkg::*;

  logic       pMmcmLocked;
  tmds_word_t pVidCh0;
  tmds_word_t pVidCh1;
  tmds_word_t pVidCh2;
  logic       pSerRst;
  tmds_word_t pTmdsCh0;
  tmds_word_t pTmdsCh1;
  tmds_word_t pTmdsCh2;
  tmds_word_t pTmdsClk;
  logic       pLinkUp;
  logic [1:0] pState;
`ifdef TMDS_LINK_DIAG_EN
  logic [kLossCntW-1:0] pLockLossCnt;
`endif

  modport master (
    output pMmcmLocked, pVidCh0, pVidCh1, pVidCh2,
    input  pSerRst, pTmdsCh0, pTmdsCh1, pTmdsCh2, pTmdsClk, pLinkUp, pState
`ifdef TMDS_LINK_DIAG_EN
    , input pLockLossCnt
`endif
  );

  modport slave (
    input  pMmcmLocked, pVidCh0, pVidCh1, pVidCh2,
    output pSerRst, pTmdsCh0, pTmdsCh1, pTmdsCh2, pTmdsClk, pLinkUp, pState
`ifdef TMDS_LINK_DIAG_EN
    , output pLockLossCnt
`endif
  );

endinterface

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous status bit, with a
// configurable synchronous reset value.
module sync_bit #(
  parameter logic kRstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= kRstVal;
      sync_q <= kRstVal;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/tmds_link_ctrl.sv
// Pixel-domain TMDS link sequencer: lock filter, serializer reset hold, control
// token warm-up, then registered video pass-through. TMDS_LINK_DIAG_EN adds a
// saturating lock-loss counter.
module tmds_link_ctrl
  import tmds_pkg::*;
#(
  parameter int unsigned kLockStableCycles = 1024,
  parameter int unsigned kRstHoldCycles    = 16,
  parameter int unsigned kWarmupCycles     = 256
) (
  input  logic            PixelClk,
  input  logic            pRst,
  tmds_link_ctrl_if.slave link
);

  localparam int unsigned kCntW = cnt_width(kLockStableCycles, kRstHoldCycles, kWarmupCycles);
  localparam logic [kCntW-1:0] kLockLast   = kCntW'(kLockStableCycles - 1);
  localparam logic [kCntW-1:0] kHoldLast   = kCntW'(kRstHoldCycles - 1);
  localparam logic [kCntW-1:0] kWarmupLast = kCntW'(kWarmupCycles - 1);

  logic        lock_sync;
  logic        lock_lost;

  link_state_e      state_q, state_d;
  logic [kCntW-1:0] cnt_q, cnt_d;
  logic             ser_rst_q, ser_rst_d;
  logic             link_up_q, link_up_d;
  tmds_rgb_t        data_q, data_d;
  tmds_word_t       clk_word_q, clk_word_d;

  sync_bit #(.kRstVal(1'b0)) u_lock_sync (
    .clk    (PixelClk),
    .rst    (pRst),
    .async_i(link.pMmcmLocked),
    .sync_o (lock_sync)
  );

  assign lock_lost = (state_q != IDLE) && !lock_sync;

  // Next state and next (registered) outputs, all derived from state_d.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_word_d = kClkPattern;

    case (state_q)
      IDLE: begin
        if (!lock_sync) begin
          cnt_d = '0;
        end else if (cnt_q == kLockLast) begin
          state_d = RST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + kCntW'(1);
        end
      end
      RST_HOLD: begin
        if (cnt_q == kHoldLast) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + kCntW'(1);
        end
      end
      WARMUP: begin
        if (cnt_q == kWarmupLast) begin
          state_d = LINK_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + kCntW'(1);
        end
      end
      LINK_UP: begin
        cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Lock loss overrides any terminal-count transition taken above.
    if (lock_lost) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    ser_rst_d = (state_d == IDLE) || (state_d == RST_HOLD);
    link_up_d = (state_d == LINK_UP);
    if (link_up_d) begin
      data_d.ch0 = link.pVidCh0;
      data_d.ch1 = link.pVidCh1;
      data_d.ch2 = link.pVidCh2;
    end else begin
      data_d.ch0 = kCtl00;
      data_d.ch1 = kCtl00;
      data_d.ch2 = kCtl00;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (pRst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ser_rst_q  <= 1'b1;
      link_up_q  <= 1'b0;
      data_q     <= {kCtl00, kCtl00, kCtl00};
      clk_word_q <= kClkPattern;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ser_rst_q  <= ser_rst_d;
      link_up_q  <= link_up_d;
      data_q     <= data_d;
      clk_word_q <= clk_word_d;
    end
  end

  assign link.pSerRst  = ser_rst_q;
  assign link.pLinkUp  = link_up_q;
  assign link.pState   = state_q;
  assign link.pTmdsCh0 = data_q.ch0;
  assign link.pTmdsCh1 = data_q.ch1;
  assign link.pTmdsCh2 = data_q.ch2;
  assign link.pTmdsClk = clk_word_q;

`ifdef TMDS_LINK_DIAG_EN
  logic [kLossCntW-1:0] loss_cnt_q, loss_cnt_d;

  // Saturating count of lock-loss teardowns; only pRst clears it.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + kLossCntW'(1);
    end
  end

  always_ff @(posedge PixelClk) begin
    if (pRst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign link.pLockLossCnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Self-checking bench for tmds_link_ctrl (params 8/4/6): edge-indexed table,
// hand-written corner sequences and random lock/reset/video against a model.
module tb_tmds_link_ctrl;
  import tmds_pkg::*;

  localparam int kLock = 8;
  localparam int kHold = 4;
  localparam int kWarm = 6;

  logic clk;
  logic rst_r;
  tmds_link_ctrl_if lnk();

  tmds_link_ctrl #(
    .kLockStableCycles(kLock),
    .kRstHoldCycles   (kHold),
    .kWarmupCycles    (kWarm)
  ) dut (
    .PixelClk(clk),
    .pRst    (rst_r),
    .link    (lnk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int edge_n;

  logic [9:0] v0, v1, v2;

  // Reference model: phase index, run of synced-high edges, edges spent in phase.
  int         m_phase, m_run, m_age, m_loss;
  logic       m_s1, m_s2;
  logic [29:0] m_data;

  typedef struct {
    int         edge_i;
    logic [1:0] st;
    logic       serrst;
    logic       linkup;
    logic [9:0] ch0;
  } tbl_t;
  tbl_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic lock);
    logic seen;
    if (rst) begin
      m_phase = 0; m_run = 0; m_age = 0; m_loss = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_data = {3{10'h354}};
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = lock;
      if (m_phase != 0 && !seen) begin
        m_phase = 0; m_run = 0; m_age = 0;
        if (m_loss < 255) m_loss++;
      end else begin
        case (m_phase)
          0: begin
            if (seen) begin
              m_run++;
              if (m_run == kLock) begin m_phase = 1; m_age = 0; m_run = 0; end
            end else m_run = 0;
          end
          1: begin
            m_age++;
            if (m_age == kHold) begin m_phase = 2; m_age = 0; end
          end
          2: begin
            m_age++;
            if (m_age == kWarm) m_phase = 3;
          end
          default: ;
        endcase
      end
      m_data = (m_phase == 3) ? {v2, v1, v0} : {3{10'h354}};
    end
  endtask

  task automatic check_all();
    logic [43:0] act, exp;
    act = {lnk.pState, lnk.pSerRst, lnk.pLinkUp, lnk.pTmdsCh2, lnk.pTmdsCh1,
           lnk.pTmdsCh0, lnk.pTmdsClk};
    exp = {2'(m_phase), (m_phase < 2), (m_phase == 3), m_data, 10'h3E0};
    check($sformatf("model_e%0d", edge_n), 64'(act), 64'(exp));
`ifdef TMDS_LINK_DIAG_EN
    check($sformatf("model_losscnt_e%0d", edge_n), 64'(lnk.pLockLossCnt), 64'(m_loss));
`endif
  endtask

  // One clock edge; a reset edge becomes edge 0.
  task automatic step(input logic rst, input logic lock);
    rst_r           = rst;
    lnk.pMmcmLocked = lock;
    lnk.pVidCh0     = v0;
    lnk.pVidCh1     = v1;
    lnk.pVidCh2     = v2;
    @(posedge clk);
    model_edge(rst, lock);
    if (rst) edge_n = 0; else edge_n++;
    #1;
    check_all();
  endtask

  task automatic chk_state(input string name, input logic [1:0] exp);
    check(name, 64'(lnk.pState), 64'(exp));
  endtask

  int hold, fall, rise;
  logic lk;

  initial begin
    n_tests = 0; n_fail = 0; edge_n = 0;
    rst_r = 1'b1;
    lnk.pMmcmLocked = 1'b0;
    v0 = 10'h155; v1 = 10'h2AA; v2 = 10'h0F3;
    lnk.pVidCh0 = v0; lnk.pVidCh1 = v1; lnk.pVidCh2 = v2;

    tbl[0] = '{0,  2'd0, 1'b1, 1'b0, 10'h354};
    tbl[1] = '{9,  2'd0, 1'b1, 1'b0, 10'h354};
    tbl[2] = '{10, 2'd1, 1'b1, 1'b0, 10'h354};
    tbl[3] = '{13, 2'd1, 1'b1, 1'b0, 10'h354};
    tbl[4] = '{14, 2'd2, 1'b0, 1'b0, 10'h354};
    tbl[5] = '{19, 2'd2, 1'b0, 1'b0, 10'h354};
    tbl[6] = '{20, 2'd3, 1'b0, 1'b1, 10'h155};
    tbl[7] = '{21, 2'd3, 1'b0, 1'b1, 10'h155};

    // Power-up sequence with lock high from edge 0.
    for (int e = 0; e <= 21; e++) begin
      step(e == 0, 1'b1);
      foreach (tbl[i]) begin
        if (tbl[i].edge_i == edge_n) begin
          check($sformatf("tbl_e%0d", edge_n),
                64'({lnk.pState, lnk.pSerRst, lnk.pLinkUp, lnk.pTmdsCh0}),
                64'({tbl[i].st, tbl[i].serrst, tbl[i].linkup, tbl[i].ch0}));
        end
      end
    end

    // Video pass-through latency in LINK_UP.
    v0 = 10'h2CC; v1 = 10'h133; v2 = 10'h0F0;
    step(1'b0, 1'b1);
    check("vid_ch0", 64'(lnk.pTmdsCh0), 64'(10'h2CC));
    check("vid_ch1", 64'(lnk.pTmdsCh1), 64'(10'h133));
    check("vid_ch2", 64'(lnk.pTmdsCh2), 64'(10'h0F0));
    check("clk_pattern", 64'(lnk.pTmdsClk), 64'(10'h3E0));

    // Lock dropped in LINK_UP, then restored: same relative timing.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_state("drop_still_up", 2'd3);
    step(1'b0, 1'b0);
    check("drop_down", 64'({lnk.pState, lnk.pSerRst, lnk.pLinkUp, lnk.pTmdsCh0}),
          64'({2'd0, 1'b1, 1'b0, 10'h354}));
    fall = -1; rise = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b1);
      if (fall < 0 && !lnk.pSerRst) fall = k;
      if (rise < 0 && lnk.pLinkUp) rise = k;
    end
    check("relock_serrst_fall", 64'(fall), 64'(14));
    check("relock_linkup_rise", 64'(rise), 64'(20));

    // One-cycle lock glitch seen by the FSM at IDLE counter 5.
    step(1'b1, 1'b1);
    for (int e = 1; e <= 16; e++) begin
      step(1'b0, (e == 6) ? 1'b0 : 1'b1);
      if (e == 10) chk_state("glitch_no_early_exit", 2'd0);
      if (e == 15) chk_state("glitch_still_idle", 2'd0);
      if (e == 16) chk_state("glitch_rst_hold", 2'd1);
    end

    // Lock loss seen on the WARMUP terminal-count edge wins.
    step(1'b1, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, (e >= 18) ? 1'b0 : 1'b1);
      if (e == 19) chk_state("warm_term_pre", 2'd2);
      if (e == 20) check("warm_term_loss", 64'({lnk.pState, lnk.pSerRst, lnk.pLinkUp}),
                         64'({2'd0, 1'b1, 1'b0}));
    end

    // pRst in WARMUP with lock high, then resume.
    step(1'b1, 1'b1);
    for (int e = 1; e <= 15; e++) step(1'b0, 1'b1);
    chk_state("pre_rst_warmup", 2'd2);
    step(1'b1, 1'b1);
    check("mid_rst_values", 64'({lnk.pState, lnk.pSerRst, lnk.pLinkUp, lnk.pTmdsCh0}),
          64'({2'd0, 1'b1, 1'b0, 10'h354}));
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b1);
      if (e == 13) chk_state("resume_e13", 2'd1);
      if (e == 14) chk_state("resume_e14", 2'd2);
      if (e == 20) chk_state("resume_e20", 2'd3);
    end

`ifdef TMDS_LINK_DIAG_EN
    // Lock-loss counter: three events, saturation, clear by pRst.
    step(1'b1, 1'b1);
    for (int ev = 0; ev < 260; ev++) begin
      for (int k = 0; k < 11; k++) step(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
      if (ev == 2) check("diag_three", 64'(lnk.pLockLossCnt), 64'(3));
    end
    check("diag_saturate", 64'(lnk.pLockLossCnt), 64'(255));
    step(1'b1, 1'b1);
    check("diag_clear", 64'(lnk.pLockLossCnt), 64'(0));
`endif

    // Random lock bursts, video and occasional reset.
    hold = 0; lk = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        if ($urandom_range(99) < 80) begin
          lk = 1'b1; hold = $urandom_range(60, 5);
        end else begin
          lk = 1'b0; hold = $urandom_range(3, 1);
        end
      end
      hold--;
      v0 = 10'($urandom); v1 = 10'($urandom); v2 = 10'($urandom);
      step($urandom_range(399) == 0, lk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
